fb_port_arbiter: RTL
====================

// Module: fb_port_arbiter
// PURPOSE
//  Single-port frame-buffer access controller shared by two requesters.
//  Requester W is the VGA capture path (pixel writes); requester R is the DVI display path (pixel reads).
//  Each cycle it grants at most one request. Reads have priority, and a starvation guard bounds write stall.
//  It drives an external single-port RAM (DEPTH x DATA_W) and returns read data with fixed latency.
//  Out-of-range accesses are handled in the arbiter: dropped writes, FILL_VALUE reads.
// PARAMETERS
//  DATA_W        24         pixel width {R,G,B}
//  ADDR_W        15         address width
//  DEPTH         30000      valid words; addr >= DEPTH is out of range
//  RD_LAT        1          RAM read latency, cycles from ram_en to ram_rdata valid (1..4)
//  STARVE_LIMIT  8          consecutive stalled write cycles before write gets forced priority
//  FILL_VALUE    24'hFFFFFF data returned for out-of-range reads
// PORTS
//  clk          in   1       single clock (cpu_clk_g domain)
//  rst_n        in   1       asynchronous active-low reset
//  wr_valid     in   1       write request
//  wr_ready     out  1       write accepted this cycle
//  wr_addr      in   ADDR_W  write address
//  wr_data      in   DATA_W  write pixel
//  rd_valid     in   1       read request
//  rd_ready     out  1       read accepted this cycle
//  rd_addr      in   ADDR_W  read address
//  rd_rvalid    out  1       read data valid (one pulse per accepted read)
//  rd_rdata     out  DATA_W  read data
//  ram_en       out  1       RAM enable
//  ram_we       out  1       RAM write enable
//  ram_addr     out  ADDR_W  RAM address
//  ram_wdata    out  DATA_W  RAM write data
//  ram_rdata    in   DATA_W  RAM read data, RD_LAT after ram_en&!ram_we
//  wr_drop_cnt  out  16      count of out-of-range writes, saturating at 16'hFFFF
//  starve_hit   out  1       forced-write condition active (debug/LED)
// BEHAVIOUR
//  - Handshake: a transfer occurs when valid&ready in the same cycle. ready may depend on valid.
//    Requesters hold addr/data stable while valid && !ready.
//  - Grant: starve_hit = (starve_cnt >= STARVE_LIMIT).
//    rd_ready = rd_valid & !(wr_valid & starve_hit); wr_ready = wr_valid & (!rd_valid | starve_hit).
//    wr_ready and rd_ready are never high together.
//  - starve_cnt, width $clog2(STARVE_LIMIT+1): clears when wr_valid==0 or on a write handshake.
//    Increments when wr_valid & !wr_ready. Saturates at STARVE_LIMIT.
//  - RAM drive, combinational from the granted request:
//    - In-range write: en=1, we=1, addr/wdata = wr_*.
//    - In-range read: en=1, we=0, addr = rd_addr.
//    - Out of range or no grant: en=0, we=0, addr/wdata = 0.
//  - Out-of-range write: still handshaken (wr_ready=1), RAM untouched, wr_drop_cnt += 1, saturating.
//  - Read return: shift register of depth RD_LAT carrying {valid, oor}.
//    rd_rvalid rises exactly RD_LAT cycles after the read handshake.
//    rd_rdata = ram_rdata (in range) or FILL_VALUE (oor).
//    Back-to-back reads return back-to-back and in order.
//  - rd_rdata holds its last value while rd_rvalid==0.
//  - Reset (async assert, sync deassert expected upstream): rd_rvalid=0, rd_rdata=0, wr_drop_cnt=0,
//    starve_cnt=0, pipeline cleared.
//    Reads in flight at reset never produce rd_rvalid. ready/ram_* are 0 while rst_n==0.
//  - Address arithmetic is compared unsigned against DEPTH. No wrap: DEPTH-1 is valid, DEPTH is oor.
// STRUCTURE
//  - Shared package fb_pkg: DATA_W, ADDR_W, FB_DEPTH (30000), FB_FILL (24'hFFFFFF),
//    typedef pixel_t [DATA_W-1:0].
//    Also shared with the capture/display blocks.
//  - One sub-module: fb_rd_pipe (RD_LAT-deep valid/oor shift register + return mux).
//  - Grant logic and counters stay in the top module.
// TESTING
//  1. Read only: rd_addr=5, RAM[5]=24'h123456, RD_LAT=1 -> rd_ready=1; next cycle rd_rvalid=1, rd_rdata=24'h123456.
//  2. Simultaneous: wr_valid=rd_valid=1 held 20 cycles, STARVE_LIMIT=8 -> rd granted cycles 0-7;
//     write granted cycle 8 (starve_hit=1); starve_cnt then 0; reads resume.
//  3. OOR: write addr 30000 -> wr_ready=1, ram_en=0, wr_drop_cnt 0->1.
//     Read addr 30001 -> rd_rvalid after RD_LAT with rd_rdata=24'hFFFFFF.
//  4. Streaming: 10 back-to-back reads, RD_LAT=3 -> 10 consecutive rd_rvalid pulses, starting 3 cycles
//     after the first handshake, data in address order.
//  5. Reset mid-flight: assert rst_n=0 one cycle after a read handshake (RD_LAT=2) -> no rd_rvalid ever;
//     all outputs at reset values immediately.
//  6. Saturation: force wr_drop_cnt to 16'hFFFE, issue 3 OOR writes -> counter sticks at 16'hFFFF.

Source files
------------

// File: rtl/fb_pkg.sv
// Frame-buffer definitions shared by the arbiter and the capture/display blocks.
package fb_pkg;

  localparam int DATA_W   = 24;
  localparam int ADDR_W   = 15;
  localparam int FB_DEPTH = 30000;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  localparam pixel_t FB_FILL = 24'hFFFFFF;

  // Addresses are compared unsigned with no wrap; DEPTH itself is out of range.
  function automatic logic fb_in_range(input fb_addr_t a, input int depth);
    return {{(32-ADDR_W){1'b0}}, a} < 32'(depth);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester handshakes plus the single-port RAM bus around the frame-buffer arbiter.
interface fb_port_arbiter_if;
  import fb_pkg::*;

  logic     wr_valid;
  logic     wr_ready;
  fb_addr_t wr_addr;
  pixel_t   wr_data;
  logic     rd_valid;
  logic     rd_ready;
  fb_addr_t rd_addr;
  logic     rd_rvalid;
  pixel_t   rd_rdata;
  logic     ram_en;
  logic     ram_we;
  fb_addr_t ram_addr;
  pixel_t   ram_wdata;
  pixel_t   ram_rdata;

  // master: requesters and the RAM; slave: the arbiter itself.
  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_rdata,
    input  wr_ready, rd_ready, rd_rvalid, rd_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_rdata,
    output wr_ready, rd_ready, rd_rvalid, rd_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/fb_rd_pipe.sv
// Read-return pipeline: RD_LAT-deep {valid, oor} shift register and return-data mux.
module fb_rd_pipe
  import fb_pkg::*;
#(
  parameter int     RD_LAT     = 1,
  parameter pixel_t FILL_VALUE = FB_FILL
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_push,
  input  logic   i_oor,
  input  pixel_t i_ram_rdata,
  output logic   o_rvalid,
  output pixel_t o_rdata
);

  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_oor;
  pixel_t            r_rdata_hold;
  pixel_t            w_ret_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_oor <= '0;
    end else begin
      r_vld[0] <= i_push;
      r_oor[0] <= i_oor;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_oor[i] <= r_oor[i-1];
      end
    end
  end

  assign w_ret_data = r_oor[RD_LAT-1] ? FILL_VALUE : i_ram_rdata;

  // The hold register keeps rd_rdata stable between returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_hold <= '0;
    end else if (r_vld[RD_LAT-1]) begin
      r_rdata_hold <= w_ret_data;
    end
  end

  assign o_rvalid = r_vld[RD_LAT-1];
  assign o_rdata  = r_vld[RD_LAT-1] ? w_ret_data : r_rdata_hold;

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads win, capture writes are starvation-guarded.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int     DEPTH        = FB_DEPTH,
  parameter int     RD_LAT       = 1,
  parameter int     STARVE_LIMIT = 8,
  parameter pixel_t FILL_VALUE   = FB_FILL
) (
  input  logic               clk,
  input  logic               rst_n,
  fb_port_arbiter_if.slave   bus,
  output logic [15:0]        wr_drop_cnt,
  output logic               starve_hit
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] r_starve_cnt;
  logic [15:0]     r_wr_drop_cnt;
  logic            w_wr_ok;
  logic            w_rd_ok;
  logic            w_wr_in;
  logic            w_rd_in;

  assign starve_hit = (r_starve_cnt >= SC_W'(STARVE_LIMIT));
  assign w_wr_in    = fb_in_range(bus.wr_addr, DEPTH);
  assign w_rd_in    = fb_in_range(bus.rd_addr, DEPTH);

  // Grants are masked by rst_n so nothing is accepted while reset is held.
  assign w_rd_ok = rst_n & bus.rd_valid & ~(bus.wr_valid & starve_hit);
  assign w_wr_ok = rst_n & bus.wr_valid & (~bus.rd_valid | starve_hit);

  assign bus.rd_ready = w_rd_ok;
  assign bus.wr_ready = w_wr_ok;
  assign wr_drop_cnt  = r_wr_drop_cnt;

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (w_wr_ok && w_wr_in) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_addr  = bus.wr_addr;
      bus.ram_wdata = bus.wr_data;
    end else if (w_rd_ok && w_rd_in) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!bus.wr_valid || w_wr_ok) begin
      r_starve_cnt <= '0;
    end else if (!starve_hit) begin
      r_starve_cnt <= r_starve_cnt + SC_W'(1);
    end
  end

  // Out-of-range writes are acknowledged but only counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_drop_cnt <= '0;
    end else if (w_wr_ok && !w_wr_in) begin
      r_wr_drop_cnt <= sat_inc16(r_wr_drop_cnt);
    end
  end

  fb_rd_pipe #(
    .RD_LAT     (RD_LAT),
    .FILL_VALUE (FILL_VALUE)
  ) u_rd_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_rd_ok),
    .i_oor       (~w_rd_in),
    .i_ram_rdata (bus.ram_rdata),
    .o_rvalid    (bus.rd_rvalid),
    .o_rdata     (bus.rd_rdata)
  );

endmodule
